// File: rtl/lin_buff_mc_pkg.sv
// Package for the lin_buff_mc sliding-window line buffer.
// Holds the parameter defaults shared with the HOG gradient stage and the row counter type.
package lin_buff_mc_pkg;

  localparam int DEF_BUFFER_WIDTH = 8;
  localparam int DEF_BUFFER_DEPTH = 40;
  localparam int DEF_CHANNELS     = 1;
  localparam int DEF_BLOCK_WIDTH  = 4;
  localparam int DEF_BLOCK_HEIGHT = 8;
  localparam int DEF_STRIDE_X     = 1;
  localparam int DEF_STRIDE_Y     = 1;
  localparam int DEF_SKIP_BORDER  = 0;

  // Row counter and frame height share one width
  typedef logic [15:0] row_t;

endpackage

// File: rtl/lin_buff_mc_line.sv
// lin_buff_line: one single-port line RAM with read-before-write at a shared address.
// The read is asynchronous so the old content at addr is visible in the same cycle
// the new content is written on the clock edge.
// Ports:
//   clk   - clock, rising edge
//   we    - write enable (one pixel accepted)
//   addr  - column address
//   wdata - data written at addr
//   rdata - data currently stored at addr (value before this cycle's write)
module lin_buff_line #(
  parameter int DEPTH = 40,
  parameter int DW    = 8,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Write port: contents are never cleared, row gating in the top keeps them from being emitted stale
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/lin_buff_mc.sv
// lin_buff_mc: turns a raster pixel stream into BLOCK_HEIGHT x BLOCK_WIDTH windows.
// Ports:
//   clk, rst              - clock; asynchronous active-low reset
//   cfg_width, cfg_height - frame size, latched with the first pixel of a frame
//   p_valid/p_ready/pixel - input pixel stream
//   k_valid/k_ready       - output window handshake (single output slot)
//   kernel                - window, cell (i,j) at [(i*BLOCK_WIDTH+j)*PW +: PW], i=0 oldest row
//   k_border              - window wraps across a line boundary
//   k_last                - last emitted window of the frame
module lin_buff_mc
  import lin_buff_mc_pkg::*;
#(
  parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH,
  parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int BLOCK_WIDTH  = DEF_BLOCK_WIDTH,
  parameter int BLOCK_HEIGHT = DEF_BLOCK_HEIGHT,
  parameter int STRIDE_X     = DEF_STRIDE_X,
  parameter int STRIDE_Y     = DEF_STRIDE_Y,
  parameter int SKIP_BORDER  = DEF_SKIP_BORDER
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [$clog2(BUFFER_DEPTH+1)-1:0]                      cfg_width,
  input  logic [15:0]                                            cfg_height,
  input  logic                                                   p_valid,
  input  logic [CHANNELS*BUFFER_WIDTH-1:0]                       pixel,
  output logic                                                   p_ready,
  output logic                                                   k_valid,
  input  logic                                                   k_ready,
  output logic [BLOCK_HEIGHT*BLOCK_WIDTH*CHANNELS*BUFFER_WIDTH-1:0] kernel,
  output logic                                                   k_border,
  output logic                                                   k_last
);

  localparam int PW  = CHANNELS * BUFFER_WIDTH;
  localparam int CW  = $clog2(BUFFER_DEPTH + 1);
  localparam int KW  = BLOCK_HEIGHT * BLOCK_WIDTH * PW;
  localparam int NL  = BLOCK_HEIGHT - 1;
  localparam int SXW = $clog2(STRIDE_X + 1);
  localparam int SYW = $clog2(STRIDE_Y + 1);

  localparam logic [CW-1:0]  COL_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  DEPTH_C   = CW'(BUFFER_DEPTH);
  localparam logic [CW-1:0]  BW_M1     = CW'(BLOCK_WIDTH - 1);
  localparam row_t           BH_M1     = 16'(BLOCK_HEIGHT - 1);
  localparam logic [SXW-1:0] SX_MAX    = SXW'(STRIDE_X - 1);
  localparam logic [SYW-1:0] SY_MAX    = SYW'(STRIDE_Y - 1);
  localparam logic [SXW-1:0] SX_ONE    = {{(SXW-1){1'b0}}, 1'b1};
  localparam logic [SYW-1:0] SY_ONE    = {{(SYW-1){1'b0}}, 1'b1};
  localparam logic           SKIP_C    = (SKIP_BORDER != 0);

  logic [CW-1:0]  col_r, width_r, eff_w_s;
  row_t           row_r, height_r, eff_h_s;
  logic [SXW-1:0] sx_r;
  logic [SYW-1:0] sy_r;
  logic [KW-1:0]  win_r, win_next_s, kernel_r;
  logic           k_valid_r, k_border_r, k_last_r;
  logic           p_ready_s, accept_s, frame_start_s, col_end_s, row_end_s;
  logic           cand_s, border_s, emit_s, last_s;
  logic [PW-1:0]  rd_s [NL];
  logic [PW-1:0]  wd_s [NL];

  assign p_ready_s = !k_valid_r || k_ready;
  assign accept_s  = p_valid && p_ready_s;

  // Frame geometry and emit decision for the pixel on the input this cycle
  always_comb begin
    frame_start_s = (col_r == {CW{1'b0}}) && (row_r == 16'd0);
    if (frame_start_s) begin
      eff_w_s = (cfg_width > DEPTH_C) ? DEPTH_C : cfg_width;
      eff_h_s = cfg_height;
    end else begin
      eff_w_s = width_r;
      eff_h_s = height_r;
    end
    col_end_s = (col_r == (eff_w_s - COL_ONE));
    row_end_s = (row_r == (eff_h_s - 16'd1));
    cand_s    = (row_r >= BH_M1);
    border_s  = (col_r < BW_M1);
    if (border_s) begin
      emit_s = cand_s && (sy_r == {SYW{1'b0}}) && !SKIP_C;
    end else begin
      emit_s = cand_s && (sy_r == {SYW{1'b0}}) && (sx_r == {SXW{1'b0}});
    end
    // Last emitting column/row: no further stride hit fits inside the frame
    last_s = !border_s
             && ((32'(col_r) + 32'(STRIDE_X)) >= 32'(eff_w_s))
             && ((32'(row_r) + 32'(STRIDE_Y)) >= 32'(eff_h_s));
  end

  // Column/row position, stride phase counters and frame size latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_r    <= {CW{1'b0}};
      row_r    <= 16'd0;
      width_r  <= {CW{1'b0}};
      height_r <= 16'd0;
      sx_r     <= {SXW{1'b0}};
      sy_r     <= {SYW{1'b0}};
    end else if (accept_s) begin
      if (frame_start_s) begin
        width_r  <= eff_w_s;
        height_r <= eff_h_s;
      end
      // sx is parked at 0 through the border columns so column BW-1 starts a stride
      if (border_s || (sx_r == SX_MAX)) begin
        sx_r <= {SXW{1'b0}};
      end else begin
        sx_r <= sx_r + SX_ONE;
      end
      if (col_end_s) begin
        col_r <= {CW{1'b0}};
        if (row_end_s) begin
          row_r <= 16'd0;
          sy_r  <= {SYW{1'b0}};
        end else begin
          row_r <= row_r + 16'd1;
          if (!cand_s || (sy_r == SY_MAX)) begin
            sy_r <= {SYW{1'b0}};
          end else begin
            sy_r <= sy_r + SY_ONE;
          end
        end
      end else begin
        col_r <= col_r + COL_ONE;
      end
    end
  end

  // Line RAM cascade: RAM[0] takes the new pixel, RAM[n] takes what RAM[n-1] held
  for (genvar n = 0; n < NL; n++) begin : g_line
    if (n == 0) begin : g_first
      assign wd_s[n] = pixel;
    end else begin : g_next
      assign wd_s[n] = rd_s[n-1];
    end
    lin_buff_line #(
      .DEPTH (BUFFER_DEPTH),
      .DW    (PW),
      .AW    (CW)
    ) u_line (
      .clk   (clk),
      .we    (accept_s),
      .addr  (col_r),
      .wdata (wd_s[n]),
      .rdata (rd_s[n])
    );
  end

  // Window shift: drop column 0, append the new column (oldest line at i=0, new pixel at the bottom)
  always_comb begin
    win_next_s = win_r;
    for (int i = 0; i < BLOCK_HEIGHT; i++) begin
      for (int j = 0; j < BLOCK_WIDTH - 1; j++) begin
        win_next_s[(i*BLOCK_WIDTH+j)*PW +: PW] = win_r[(i*BLOCK_WIDTH+j+1)*PW +: PW];
      end
    end
    for (int i = 0; i < NL; i++) begin
      win_next_s[(i*BLOCK_WIDTH+BLOCK_WIDTH-1)*PW +: PW] = rd_s[NL-1-i];
    end
    win_next_s[KW-PW +: PW] = pixel;
  end

  // Window shift register and single output slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_r      <= {KW{1'b0}};
      kernel_r   <= {KW{1'b0}};
      k_valid_r  <= 1'b0;
      k_border_r <= 1'b0;
      k_last_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        win_r <= win_next_s;
      end
      if (accept_s && emit_s) begin
        kernel_r   <= win_next_s;
        k_valid_r  <= 1'b1;
        k_border_r <= border_s;
        k_last_r   <= last_s;
      end else if (k_ready) begin
        k_valid_r <= 1'b0;
      end
    end
  end

  assign p_ready  = p_ready_s;
  assign k_valid  = k_valid_r;
  assign kernel   = kernel_r;
  assign k_border = k_border_r;
  assign k_last   = k_last_r;

endmodule

// File: tb/tb_lin_buff_mc.sv
// Scoreboard bench for lin_buff_mc. dut_a uses default parameters, dut_b uses
// STRIDE_X=2, STRIDE_Y=2, SKIP_BORDER=1. Pixel value for (r,c) is (r*W+c)&8'hFF, so
// window cell (i,j) for pixel index p is p-(BW-1-j)-(BH-1-i)*W; cells with a negative
// index hold data from before the frame and are not compared.
module tb_lin_buff_mc;

  localparam int PW = 8;
  localparam int CW = 6;
  localparam int KW = 8 * 4 * PW;

  typedef struct {
    int p;
    int w;
    bit border;
    bit last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] cfg_width = 6'd10;
  logic [15:0]   cfg_height = 16'd8;
  logic          p_valid = 1'b0;
  logic          en_b = 1'b0;
  logic [PW-1:0] pixel = 8'd0;
  logic          k_ready = 1'b1;
  logic          p_valid_a, p_valid_b;
  logic          p_ready_a, k_valid_a, k_border_a, k_last_a;
  logic          p_ready_b, k_valid_b, k_border_b, k_last_b;
  logic [KW-1:0] kernel_a, kernel_b;

  int   checks = 0;
  int   failures = 0;
  exp_t qa[$];
  exp_t qb[$];

  assign p_valid_a = p_valid & ~en_b;
  assign p_valid_b = p_valid & en_b;

  always #5 clk = ~clk;

  lin_buff_mc dut_a (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .p_valid(p_valid_a), .pixel(pixel), .p_ready(p_ready_a),
    .k_valid(k_valid_a), .k_ready(k_ready), .kernel(kernel_a),
    .k_border(k_border_a), .k_last(k_last_a)
  );

  lin_buff_mc #(.STRIDE_X(2), .STRIDE_Y(2), .SKIP_BORDER(1)) dut_b (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .p_valid(p_valid_b), .pixel(pixel), .p_ready(p_ready_b),
    .k_valid(k_valid_b), .k_ready(k_ready), .kernel(kernel_b),
    .k_border(k_border_b), .k_last(k_last_b)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic bit emit_f(int r, int c, int sx, int sy, bit skip);
    if (r < 7) return 1'b0;
    if (((r - 7) % sy) != 0) return 1'b0;
    if (c < 3) return !skip;
    return ((c - 3) % sx) == 0;
  endfunction

  function automatic bit gap_on(int cyc);
    if (cyc < 8) return 1'b1;
    if (cyc < 13) return 1'b0;
    if (cyc < 33) return 1'b1;
    if (cyc < 41) return 1'b0;
    return 1'b1;
  endfunction

  task automatic cmp_window(input bit sel, input logic [KW-1:0] k, input logic kb, input logic kl);
    exp_t e;
    int   idx, got, req, bi, bj;
    bit   bad;
    if ((sel ? qb.size() : qa.size()) == 0) begin
      checks++;
      failures++;
      $display("FAIL window_unexpected dut=%0d: got a window, required none", sel);
      return;
    end
    e = sel ? qb.pop_front() : qa.pop_front();
    bad = 1'b0;
    got = 0; req = 0; bi = 0; bj = 0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) begin
        idx = e.p - (3 - j) - (7 - i) * e.w;
        if (idx >= 0 && !bad && k[(i*4+j)*PW +: PW] !== idx[7:0]) begin
          bad = 1'b1;
          got = int'(k[(i*4+j)*PW +: PW]);
          req = int'(idx[7:0]);
          bi = i;
          bj = j;
        end
      end
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL kernel dut=%0d p=%0d cell(%0d,%0d): got %0d, required %0d", sel, e.p, bi, bj, got, req);
    end
    check($sformatf("k_border dut=%0d p=%0d", sel, e.p), int'(kb), int'(e.border));
    check($sformatf("k_last dut=%0d p=%0d", sel, e.p), int'(kl), int'(e.last));
  endtask

  // Monitor: a window is consumed on the next edge when k_valid & k_ready
  always @(negedge clk) begin
    if (rst && k_valid_a && k_ready) cmp_window(1'b0, kernel_a, k_border_a, k_last_a);
    if (rst && k_valid_b && k_ready) cmp_window(1'b1, kernel_b, k_border_b, k_last_b);
  end

  task automatic run_frame(input bit sel, input int w, input int h, input int nw, input int nh,
                           input bit gaps, input int stall_at, input int rst_at);
    int   sx, sy, lr, lc, cyc, r, c;
    bit   skip, acc;
    exp_t e;
    logic [KW-1:0] held;
    sx = sel ? 2 : 1;
    sy = sel ? 2 : 1;
    skip = sel;
    lr = -1;
    lc = -1;
    for (int rr = 0; rr < h; rr++)
      for (int cc = 0; cc < w; cc++)
        if (emit_f(rr, cc, sx, sy, skip)) begin lr = rr; lc = cc; end
    en_b = sel;
    cfg_width = w[CW-1:0];
    cfg_height = h[15:0];
    cyc = 0;
    for (int p = 0; p < w * h; p++) begin
      r = p / w;
      c = p % w;
      if (p == rst_at) begin
        p_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_k_valid", int'(k_valid_a), 0);
        check("rst_k_border", int'(k_border_a), 0);
        check("rst_k_last", int'(k_last_a), 0);
        check("rst_kernel_zero", int'(|kernel_a), 0);
        #2 rst = 1'b1;
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1;
        return;
      end
      while (gaps && !gap_on(cyc)) begin
        p_valid = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
      end
      p_valid = 1'b1;
      pixel = p[7:0];
      if (p == stall_at) begin
        k_ready = 1'b0;
        @(negedge clk);
        held = kernel_a;
        for (int t = 0; t < 5; t++) begin
          @(posedge clk);
          #1;
          @(negedge clk);
          check("stall_p_ready", int'(p_ready_a), 0);
          check("stall_k_valid", int'(k_valid_a), 1);
          check("stall_kernel_changed", int'(kernel_a != held), 0);
        end
        @(posedge clk);
        #1;
        k_ready = 1'b1;
      end
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        @(negedge clk);
        if (sel ? p_ready_b : p_ready_a) begin
          acc = 1'b1;
          if (emit_f(r, c, sx, sy, skip)) begin
            e.p = p;
            e.w = w;
            e.border = (c < 3);
            e.last = (r == lr) && (c == lc);
            if (sel) qb.push_back(e);
            else qa.push_back(e);
          end
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout p=%0d: got no p_ready, required accept", p);
      end
      if (p == 0) begin
        cfg_width = nw[CW-1:0];
        cfg_height = nh[15:0];
      end
    end
    p_valid = 1'b0;
    for (int t = 0; t < 20 && (qa.size() + qb.size()) != 0; t++) begin
      @(posedge clk);
      #1;
    end
    check("drain_pending_windows", qa.size() + qb.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_k_valid_a", int'(k_valid_a), 0);
    check("reset_k_border_a", int'(k_border_a), 0);
    check("reset_k_last_a", int'(k_last_a), 0);
    check("reset_kernel_a", int'(|kernel_a), 0);
    check("reset_k_valid_b", int'(k_valid_b), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_p_ready_a", int'(p_ready_a), 1);
    check("reset_p_ready_b", int'(p_ready_b), 1);

    // 1: gap-free 10x8
    run_frame(1'b0, 10, 8, 10, 8, 1'b0, -1, -1);
    // 2: consumer stall mid-row 7
    run_frame(1'b0, 10, 8, 10, 8, 1'b0, 75, -1);
    // 3: p_valid bubbles
    run_frame(1'b0, 10, 8, 10, 8, 1'b1, -1, -1);
    // 4: strided, border suppressed
    run_frame(1'b1, 10, 8, 10, 8, 1'b0, -1, -1);
    // 5: reset mid-row 7, then a full frame
    run_frame(1'b0, 10, 8, 10, 8, 1'b0, -1, 75);
    check("post_rst_p_ready", int'(p_ready_a), 1);
    run_frame(1'b0, 10, 8, 10, 8, 1'b0, -1, -1);
    // 6: frame size change (new cfg presented during the previous frame)
    run_frame(1'b0, 10, 8, 16, 9, 1'b0, -1, -1);
    run_frame(1'b0, 16, 9, 10, 8, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
